// File: rtl/uart_stim_pkg.sv
// Shared types and constants for the UART stimulus transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_stim_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int DEFAULT_CLK_DIV = 234;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo
  import uart_stim_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full     = (level == (AW+1)'(DEPTH));
    empty    = (level == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_stim.sv
// FIFO-fed UART transmitter (8 data bits, LSB first, 1 or 2 stop bits).
// Define UART_TX_PARITY_EN to add a parity bit and the parity_odd input.
module uart_tx_stim
  import uart_stim_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  input  logic                          in_valid,
  input  logic [UART_DATA_W-1:0]        in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0]  STOP_LAST   = 3'(STOP_BITS - 1);

  state_t                 state, state_next;
  logic [15:0]            baud_cnt, baud_next;
  logic [2:0]             bit_cnt, bit_next;
  logic [UART_DATA_W-1:0] shift, shift_next;
  logic                   tx_next;
  logic                   baud_zero;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit, parity_next;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid & in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  always_comb begin
    baud_zero  = (baud_cnt == '0);
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    tx_next    = tx;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_bit;
`endif
    if (state != IDLE) baud_next = baud_zero ? BAUD_RELOAD : baud_cnt - 16'd1;
    case (state)
      IDLE: ;
      START: begin
        if (baud_zero) begin
          tx_next    = shift[0];
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_zero) begin
          if (bit_cnt == 3'd7) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_bit;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            shift_next = shift >> 1;
            tx_next    = shift[1];
            bit_next   = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_zero) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_zero) begin
          if (bit_cnt == STOP_LAST) begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // A pop (from IDLE or at the last stop-bit boundary) overrides the above,
    // which is what gives back-to-back frames with no idle gap.
    if (fifo_pop) begin
      state_next = START;
      tx_next    = 1'b0;
      baud_next  = BAUD_RELOAD;
      bit_next   = '0;
      shift_next = fifo_head;
`ifdef UART_TX_PARITY_EN
      parity_next = (^fifo_head) ^ parity_odd;
`endif
    end
  end

  always_comb begin
    fifo_pop = ~fifo_empty &
               ((state == IDLE) | ((state == STOP) & baud_zero & (bit_cnt == STOP_LAST)));
    in_ready = ~fifo_full;
    busy     = (state != IDLE) | (fifo_level != '0);
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed self-checking bench for uart_tx_stim (fast instance CLK_DIV=4 and
// a 234-divider / 2-stop-bit instance). Honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_stim;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB      = 11;
  localparam int HIGH2   = 2574;
  localparam int PERIOD2 = 2808;
`else
  localparam int NB      = 10;
  localparam int HIGH2   = 2340;
  localparam int PERIOD2 = 2574;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, tx, busy;
  logic [7:0] in_data;
  logic [2:0] fifo_level;
  logic       in_valid2, in_ready2, tx2, busy2;
  logic [7:0] in_data2;
  logic [2:0] fifo_level2;
  logic       parity_odd, parity_odd2;

  int checks = 0;
  int errors = 0;

  uart_tx_stim #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_stim #(.CLK_DIV(234), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd2),
`endif
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a start bit, then samples every bit of the frame mid-cell.
  task automatic rx_frame(output logic [10:0] f, output bit to);
    int n;
    n  = 0;
    f  = '1;
    to = 1'b0;
    while (tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) begin
      to = 1'b1;
      return;
    end
    for (int k = 0; k < NB; k++) begin
      repeat (k == 0 ? 2 : 4) tick();
      f[k] = tx;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_wait: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (tx2 !== 1'b1)        begin errors++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    rst = 1'b0;
    tick();
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL release_tx: got %b want 1", tx); end
  endtask

  task automatic test_single();
    logic [10:0] seq;
    int bad;
`ifdef UART_TX_PARITY_EN
    seq = 11'b10010000010;
`else
    seq = 11'b01010000010;
`endif
    in_valid = 1'b1;
    in_data  = 8'h41;
    tick();
    in_valid = 1'b0;
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL single_pre_tx: got %b want 1", tx); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    tick();
    bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx !== seq[k/DIV]) begin
        errors++;
        if (bad < 4) $display("FAIL single_line[%0d]: got %b want %b", k, tx, seq[k/DIV]);
        bad++;
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_end: got %b want 1", tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [5];
    msg = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
    fork
      begin
        for (int i = 0; i < 5; i++) push_byte(msg[i]);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level_full: got %0d want 4", fifo_level); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); end
      end
      begin
        logic [10:0] fr;
        bit to;
        for (int f = 0; f < 5; f++) begin
          rx_frame(fr, to);
          checks++; if (to) begin errors++; $display("FAIL b2b_timeout[%0d]: no start bit", f); end
          checks++; if (fr[8:1] !== msg[f]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", f, fr[8:1], msg[f]); end
          checks++; if (fr[NB-1] !== 1'b1) begin errors++; $display("FAIL b2b_stop[%0d]: got %b want 1", f, fr[NB-1]); end
          repeat (2) tick();
          if (f < 4) begin
            checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: tx=%b want 0 (next start)", f, tx); end
          end else begin
            checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: tx=%b busy=%b want 1/0", tx, busy); end
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [10:0] fr;
    bit to;
    int lows;
    in_valid = 1'b1;
    in_data  = 8'h55; tick();
    in_data  = 8'hAA; tick();
    in_data  = 8'h11; tick();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL rmid_level: got %0d want 2", fifo_level); end
    repeat (8) tick();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rmid_bit1: got %b want 0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL rmid_tx: got %b want 1", tx); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_flush: got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0)     begin errors++; $display("FAIL rmid_quiet: %0d low cycles want 0", lows); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: busy=%b want 0", busy); end
    push_byte(8'h3C);
    rx_frame(fr, to);
    checks++; if (to || fr[8:1] !== 8'h3C) begin errors++; $display("FAIL rmid_after: got %h timeout=%b want 3c", fr[8:1], to); end
    repeat (2) tick();
  endtask

  task automatic test_full_pop();
    logic [7:0] msg [6];
    msg = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h66};
    fork
      begin
        int n;
        for (int i = 0; i < 5; i++) push_byte(msg[i]);
        in_valid = 1'b1;
        in_data  = 8'h66;
        checks++; if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL full_state: ready=%b level=%0d want 0/4", in_ready, fifo_level); end
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
          tick();
          n++;
        end
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_refuse: level=%0d want 3", fifo_level); end
        tick();
        in_valid = 1'b0;
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_retry: level=%0d want 4", fifo_level); end
      end
      begin
        logic [10:0] fr;
        bit to;
        for (int f = 0; f < 6; f++) begin
          rx_frame(fr, to);
          checks++; if (to || fr[8:1] !== msg[f]) begin errors++; $display("FAIL full_data[%0d]: got %h timeout=%b want %h", f, fr[8:1], to, msg[f]); end
          repeat (2) tick();
        end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end: tx=%b busy=%b want 1/0", tx, busy); end
      end
    join
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] fr;
    bit to;
    logic [7:0] d [3];
    logic       po [3];
    logic       exp_p [3];
    d = '{8'h07, 8'h03, 8'h07};
    po = '{1'b0, 1'b0, 1'b1};
    exp_p = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      parity_odd = po[i];
      push_byte(d[i]);
      rx_frame(fr, to);
      checks++; if (to || fr[8:1] !== d[i]) begin errors++; $display("FAIL par_data[%0d]: got %h want %h", i, fr[8:1], d[i]); end
      checks++; if (fr[9] !== exp_p[i])     begin errors++; $display("FAIL par_bit[%0d]: got %b want %b", i, fr[9], exp_p[i]); end
      checks++; if (fr[10] !== 1'b1)        begin errors++; $display("FAIL par_stop[%0d]: got %b want 1", i, fr[10]); end
      repeat (2) tick();
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL par_len[%0d]: busy=%b want 0", i, busy); end
    end
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_stop2();
    int n, lowc, highc;
    in_valid2 = 1'b1;
    in_data2  = 8'hFF;
    tick();
    in_valid2 = 1'b0;
    checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL s2_pre: tx2=%b want 1", tx2); end
    tick();
    lowc = 0;
    while (tx2 === 1'b0 && lowc < 5000) begin
      lowc++;
      tick();
    end
    in_valid2 = 1'b1;
    highc = 0;
    while (tx2 === 1'b1 && highc < 5000) begin
      highc++;
      tick();
      in_valid2 = 1'b0;
    end
    checks++; if (lowc != 234)            begin errors++; $display("FAIL s2_start: %0d cycles want 234", lowc); end
    checks++; if (highc != HIGH2)         begin errors++; $display("FAIL s2_high: %0d cycles want %0d", highc, HIGH2); end
    checks++; if (lowc + highc != PERIOD2) begin errors++; $display("FAIL s2_period: %0d cycles want %0d", lowc + highc, PERIOD2); end
    n = 0;
    while (busy2 !== 1'b0 && n < 4000) begin
      tick();
      n++;
    end
    checks++; if (busy2 !== 1'b0 || tx2 !== 1'b1 || fifo_level2 !== 3'd0) begin errors++; $display("FAIL s2_drain: busy2=%b tx2=%b level2=%0d want 0/1/0", busy2, tx2, fifo_level2); end
  endtask

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_valid2   = 1'b0;
    in_data2    = '0;
    parity_odd  = 1'b0;
    parity_odd2 = 1'b1;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_full_pop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stop2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
